// File: rtl/video_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_axis_pkg
// Purpose  : Shared types for the camera-to-AXI4-Stream video bridge.
// Revision : 1.0
// ============================================================================
package video_axis_pkg;

  localparam int c_pix_w = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } vab_state_t;

  typedef struct packed {
    logic               user;
    logic               last;
    logic [c_pix_w-1:0] data;
  } fifo_word_t;

  localparam int c_word_w = $bits(fifo_word_t);

endpackage
`default_nettype wire

// File: rtl/vab_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vab_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with a registered output
//            stage; occupancy counts the output register as one entry.
// Revision : 1.0
// ============================================================================
module vab_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic w_pop;
  logic w_mem_empty;
  logic w_load;

  assign w_pop       = r_valid & i_rd_en;
  // Storage holds everything except the word parked in the output register.
  assign w_mem_empty = (r_count == c_cw'(r_valid));
  assign w_load      = ~w_mem_empty & (~r_valid | w_pop);
  assign o_full      = (r_count == c_cw'(DEPTH));
  assign o_rd_data   = r_data;
  assign o_rd_valid  = r_valid;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_count <= r_count + c_cw'(i_wr_en) - c_cw'(w_pop);
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_load) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
        r_valid  <= 1'b1;
      end else if (w_pop) begin
        r_valid  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module   : video_axis_bridge
// Purpose  : DVP pixel stream to AXI4-Stream video master; drops the rest of a
//            frame on overflow or bad line length. Optional frame/drop
//            statistics ports: define VIDEO_AXIS_BRIDGE_STAT_EN.
// Revision : 1.0
// ============================================================================
module video_axis_bridge
  import video_axis_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        video_clk,
  input  logic        rst,
  input  logic [15:0] video_data,
  input  logic        video_hsync,
  input  logic        video_vsync,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        line_err
`ifdef VIDEO_AXIS_BRIDGE_STAT_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int             c_pw   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(H_ACTIVE - 1);

  logic [15:0]     r_d;
  logic            r_hs;
  logic            r_hs_d;
  logic            r_vs;
  logic            r_vs_d;

  vab_state_t      r_state;
  logic            r_sof_pend;
  logic            r_last_wr;
  logic [c_pw-1:0] r_pix_cnt;

  logic            w_vs_fall;
  logic            w_hs_fall;
  logic            w_pix;
  logic            w_short;
  logic            w_long;
  logic            w_room;
  logic            w_push;
  logic            w_ovf;
  logic            w_is_last;
  logic            w_pop;
  logic            w_fifo_full;
  fifo_word_t      w_wr_word;
  fifo_word_t      w_rd_word;
  logic [c_word_w-1:0] w_rd_bits;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_d    <= '0;
      r_hs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_d    <= video_data;
      r_hs   <= video_hsync;
      r_hs_d <= r_hs;
      r_vs   <= video_vsync;
      r_vs_d <= r_vs;
    end
  end

  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_hs_fall = r_hs_d & ~r_hs;
  // A vsync fall outranks everything, including a pixel in the same cycle.
  assign w_pix     = (r_state == ACTIVE) & r_hs & ~r_vs & ~w_vs_fall;
  assign w_long    = w_pix & r_last_wr;
  assign w_short   = (r_state == ACTIVE) & ~w_vs_fall & w_hs_fall & (r_pix_cnt != '0);
  assign w_pop     = m_axis_tvalid & m_axis_tready;
  assign w_room    = ~w_fifo_full | w_pop;
  assign w_push    = w_pix & ~w_long & w_room;
  assign w_ovf     = w_pix & ~w_long & ~w_room;
  assign w_is_last = (r_pix_cnt == c_last);

  assign w_wr_word.user = r_sof_pend;
  assign w_wr_word.last = w_is_last;
  assign w_wr_word.data = r_d;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sof_pend <= 1'b0;
      r_last_wr  <= 1'b0;
      r_pix_cnt  <= '0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      line_err  <= 1'b0;
      r_last_wr <= 1'b0;
      if (w_vs_fall) begin
        r_state    <= ACTIVE;
        r_sof_pend <= 1'b1;
        r_pix_cnt  <= '0;
      end else if (r_state == ACTIVE) begin
        if (w_short) begin
          line_err  <= 1'b1;
          r_pix_cnt <= '0;
          r_state   <= DROP;
        end else if (w_long) begin
          line_err <= 1'b1;
          r_state  <= DROP;
        end else if (w_ovf) begin
          overflow <= 1'b1;
          r_state  <= DROP;
        end else if (w_push) begin
          r_sof_pend <= 1'b0;
          r_last_wr  <= w_is_last;
          r_pix_cnt  <= w_is_last ? '0 : r_pix_cnt + c_pw'(1);
        end
      end
    end
  end

  vab_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_word_w)
  ) u_fifo (
    .clk        (video_clk),
    .rst        (rst),
    .i_wr_en    (w_push),
    .i_wr_data  (w_wr_word),
    .i_rd_en    (m_axis_tready),
    .o_rd_data  (w_rd_bits),
    .o_rd_valid (m_axis_tvalid),
    .o_full     (w_fifo_full)
  );

  assign w_rd_word    = w_rd_bits;
  assign m_axis_tdata = w_rd_word.data;
  assign m_axis_tuser = w_rd_word.user;
  assign m_axis_tlast = w_rd_word.last;

`ifdef VIDEO_AXIS_BRIDGE_STAT_EN
  logic w_drop_entry;

  assign w_drop_entry = w_short | w_long | w_ovf;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (w_pop & m_axis_tuser) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (w_drop_entry && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_axis_bridge
// Purpose  : Directed frame-level bench for video_axis_bridge (H_ACTIVE=8,
//            FIFO_DEPTH=16) with an expected-beat queue model.
// Revision : 1.0
// ============================================================================
module tb_video_axis_bridge;

  localparam int H     = 8;
  localparam int DEPTH = 16;

  logic        video_clk = 1'b0;
  logic        rst;
  logic [15:0] video_data;
  logic        video_hsync;
  logic        video_vsync;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic        line_err;
`ifdef VIDEO_AXIS_BRIDGE_STAT_EN
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 video_clk = ~video_clk;

  video_axis_bridge #(
    .H_ACTIVE   (H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .video_clk     (video_clk),
    .rst           (rst),
    .video_data    (video_data),
    .video_hsync   (video_hsync),
    .video_vsync   (video_vsync),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .line_err      (line_err)
`ifdef VIDEO_AXIS_BRIDGE_STAT_EN
    ,
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state: expected beats as {user, last, data}, expected pulse counts.
  logic [17:0] expq[$];
  int          exp_ovf  = 0;
  int          exp_lerr = 0;
  logic [15:0] pix_seq  = 16'h0100;

  int          cyc = 0;
  int          mode = 0;
  int          seen_ovf = 0;
  int          seen_lerr = 0;
  int          beat_idx = 0;
  int          n_last = 0;
  int          n_last_pos = 0;
  int          user_idx[$];
  bit          rec = 1'b0;
  bit          lat_req = 1'b0;
  bit          lat_arm = 1'b0;
  int          first_pix_cyc = 0;
  int          first_valid_cyc = 0;
  bit          want_first = 1'b0;
  logic [17:0] first_word = '0;
  bit          prev_stall = 1'b0;
  logic [17:0] prev_word = '0;

  always @(posedge video_clk) cyc <= cyc + 1;

  always @(posedge video_clk) begin
    #1;
    case (mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'b0;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge video_clk) begin
    logic [17:0] w;
    w = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (overflow) seen_ovf++;
      if (line_err) seen_lerr++;
      if (prev_stall) begin
        chk("stall_tvalid", longint'(m_axis_tvalid), 1);
        chk("stall_word", longint'(w), longint'(prev_word));
      end
      if (lat_arm && m_axis_tvalid) begin
        first_valid_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", w);
        end else begin
          chk("beat", longint'(w), longint'(expq.pop_front()));
        end
        if (want_first) begin
          first_word = w;
          want_first = 1'b0;
        end
        if (rec) begin
          if (m_axis_tuser) user_idx.push_back(beat_idx);
          if (m_axis_tlast) begin
            n_last++;
            if (beat_idx % 8 == 7) n_last_pos++;
          end
          beat_idx++;
        end
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready;
      prev_word  = w;
    end
  end

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  // Drives one frame and records what downstream must see: pixels are kept
  // until the first overflow (delivered==keep), short line or long line.
  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input int keep, input int gap);
    int delivered = 0;
    bit first = 1'b1;
    bit stop = 1'b0;
    video_vsync = 1'b1;
    repeat (4) tick();
    video_vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : H;
      for (int p = 0; p < len; p++) begin
        video_hsync = 1'b1;
        video_data  = pix_seq;
        if (lat_req) begin
          first_pix_cyc = cyc;
          lat_arm = 1'b1;
          lat_req = 1'b0;
        end
        if (!stop) begin
          if (p >= H) begin
            stop = 1'b1;
            exp_lerr++;
          end else if (delivered == keep) begin
            stop = 1'b1;
            exp_ovf++;
          end else begin
            expq.push_back({first, (p == H - 1), pix_seq});
            first = 1'b0;
            delivered++;
          end
        end
        pix_seq++;
        tick();
      end
      video_hsync = 1'b0;
      if (!stop && len < H) begin
        stop = 1'b1;
        exp_lerr++;
      end
      repeat (gap) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, longint'(expq.size()), 0);
    repeat (5) tick();
    chk({name, "_ovf_cnt"}, seen_ovf, exp_ovf);
    chk({name, "_lerr_cnt"}, seen_lerr, exp_lerr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] frame_start;
    rst         = 1'b1;
    video_data  = '0;
    video_hsync = 1'b0;
    video_vsync = 1'b0;
    repeat (3) @(posedge video_clk);
    @(negedge video_clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_line_err", line_err, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Nominal stream: 4 frames x 3 lines, tready held high.
    mode    = 0;
    rec     = 1'b1;
    lat_req = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(3, -1, 0, 1000, 3);
    wait_drain("nominal");
    rec = 1'b0;
    chk("nominal_beats", beat_idx, 96);
    chk("nominal_tuser_n", longint'(user_idx.size()), 4);
    for (int i = 0; i < user_idx.size(); i++) chk("nominal_tuser_idx", user_idx[i], 24 * i);
    chk("nominal_tlast_n", n_last, 12);
    chk("nominal_tlast_pos", n_last_pos, 12);
    chk("latency_after_capture", first_valid_cyc - first_pix_cyc - 1, 2);

    // Back-pressure from frame start: 16 entries fit, 17th pixel overflows.
    mode = 1;
    repeat (2) tick();
    send_frame(3, -1, 0, 16, 3);
    mode = 0;
    wait_drain("ovf_frame");
    chk("ovf_pulses", seen_ovf, 1);
    send_frame(3, -1, 0, 1000, 3);
    wait_drain("ovf_next");
`ifdef VIDEO_AXIS_BRIDGE_STAT_EN
    chk("stat_frame_cnt", frame_cnt, 6);
    chk("stat_drop_cnt", drop_cnt, 1);
`endif

    // Short line (5 of 8 pixels) on line 1, then a clean frame.
    send_frame(3, 1, 5, 1000, 3);
    wait_drain("short");
    chk("short_lerr", seen_lerr, 1);
    send_frame(3, -1, 0, 1000, 3);
    wait_drain("short_next");

    // Long line (10 pixels) on line 0, then a clean frame.
    send_frame(3, 0, 10, 1000, 3);
    wait_drain("long");
    chk("long_lerr", seen_lerr, 2);
    send_frame(3, -1, 0, 1000, 3);
    wait_drain("long_next");

    // Random back-pressure across 10 frames with wide line gaps.
    mode = 2;
    for (int f = 0; f < 10; f++) send_frame(3, -1, 0, 1000, 16);
    wait_drain("random");
    mode = 0;
    repeat (3) tick();

    // Reset mid-line with data parked in the output stage.
    mode = 1;
    repeat (2) tick();
    video_vsync = 1'b1;
    repeat (4) tick();
    video_vsync = 1'b0;
    repeat (2) tick();
    for (int p = 0; p < 6; p++) begin
      video_hsync = 1'b1;
      video_data  = pix_seq;
      pix_seq++;
      tick();
    end
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", m_axis_tvalid, 0);
    expq.delete();
    video_hsync = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    mode = 0;
    repeat (3) tick();
    frame_start = pix_seq;
    want_first  = 1'b1;
    send_frame(3, -1, 0, 1000, 3);
    wait_drain("post_rst");
    chk("post_rst_first_user", first_word[17], 1);
    chk("post_rst_first_data", first_word[15:0], frame_start);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_axis_bridge.md
# video_axis_bridge

Converts the captured 16-bit camera pixel stream (`video_data` qualified by `video_hsync` line-valid and `video_vsync` frame strobe) into an AXI4-Stream video master with `tuser` (start of frame) and `tlast` (end of line). It sits directly downstream of the DVP capture stage in the OV5640 shell and feeds the VDMA/frame-buffer path. A small FIFO absorbs back-pressure. On overflow, the remainder of the frame is dropped cleanly and the block resynchronises on the next frame.

## Interface
- `H_ACTIVE`, default 1280: pixels per line.
- `FIFO_DEPTH`, default 64: FIFO entries; must be a power of 2 and at least 4.
- `video_clk`  in  1: pixel clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `video_data`  in  16: RGB565 pixel.
- `video_hsync`  in  1: high means the current pixel is valid (line active).
- `video_vsync`  in  1: high during frame blanking; the falling edge starts a frame.
- `m_axis_tdata`  out  16: pixel.
- `m_axis_tvalid`  out  1: output pixel valid.
- `m_axis_tready`  in  1: downstream ready.
- `m_axis_tuser`  out  1: high on the first pixel of a frame.
- `m_axis_tlast`  out  1: high on pixel `H_ACTIVE-1` of each line.
- `overflow`  out  1: one-cycle pulse when a pixel is lost because the FIFO is full.
- `line_err`  out  1: one-cycle pulse when a line is short or long.

## Operation
- Inputs are registered once: `d_q`, `hs_q`, `vs_q`, plus `vs_qq` for edge detection.
- FSM states: `IDLE`, `ACTIVE`, `DROP`.
  - Reset enters `IDLE`.
  - Any state goes to `ACTIVE` on the vsync falling edge (`vs_qq & ~vs_q`). This also sets `sof_pend=1` and `pix_cnt=0`.
  - In `IDLE` and `DROP`, all pixels are ignored.
  - While `vs_q=1`, pixels are ignored in every state.
- In `ACTIVE`, each cycle with `hs_q=1`:
  - If `pix_cnt < H_ACTIVE` and the FIFO is not full:
    - Write `{sof_pend, pix_cnt==H_ACTIVE-1, d_q}`.
    - Clear `sof_pend`.
    - Increment `pix_cnt`; it wraps to 0 after `H_ACTIVE-1`.
  - If `pix_cnt < H_ACTIVE` and the FIFO is full:
    - Discard the pixel.
    - Pulse `overflow`.
    - Go to `DROP`.
  - If `pix_cnt >= H_ACTIVE`: this cannot occur, because the counter wraps. Long lines are therefore detected as described next.
- Line checks, using `hs_q` falling edge (`hs_qq & ~hs_q`):
  - If `pix_cnt != 0` at the edge, the line was short. Pulse `line_err`, reset `pix_cnt=0`, and go to `DROP`. No `tlast` is emitted for the truncated line.
  - Long line: when a line's `tlast` pixel has been written and `hs_q` is still high on the next cycle, the line is long. Pulse `line_err` once and go to `DROP`.
- Once `sof_pend` is cleared, `tuser` appears exactly once per frame.
- A frame truncated by `DROP` is terminated, from downstream's view, by the next `tuser`.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tuser=0`, `m_axis_tlast=0`, `overflow=0`, `line_err=0`. The FIFO is empty and the FSM is in `IDLE`.
- Reset asserted mid-frame clears everything asynchronously. `tvalid` drops in the same cycle, and the partial line is lost.
- Latency with an empty FIFO and `tready=1`: pixel presented before edge 0, captured at edge 0, written at edge 1, and `tvalid`/`tdata` valid after edge 2.
- The FIFO has a registered first-word-fall-through output.
- Pop occurs on `tvalid & tready`.
- `tdata`/`tuser`/`tlast` are stable while `tvalid & ~tready`.
- `tvalid` never depends combinationally on `tready`.
- Full is computed from a count including the output register. A simultaneous push and pop at full is a write, not an overflow.
- A vsync falling edge coinciding with `hs_q=1`: the edge takes priority and that pixel is ignored.
- Sustained throughput: 1 pixel/cycle.

## Configuration
- `VIDEO_AXIS_BRIDGE_STAT_EN` defined adds the following outputs:
  - `frame_cnt[31:0]`: increments on every `tuser` handshake and wraps.
  - `drop_cnt[15:0]`: increments on entry to `DROP` and saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: these ports and their logic are absent.

## Structure
- `video_axis_pkg` holds the FSM state enum (`IDLE`, `ACTIVE`, `DROP`) and the FIFO word struct `{user, last, data[15:0]}` (18 bits).
- Sub-module `vab_fifo`: synchronous FWFT FIFO parameterised by `DEPTH` and `WIDTH`, with the same asynchronous active-high reset.

## Test plan
- 4 frames of 3 lines with `H_ACTIVE=8` and `tready=1` → 96 beats. `tuser` on beats 0, 24, 48 and 72. `tlast` on every 8th beat. Data matches the input ramp and first `tvalid` is 2 cycles after the first capture.
- `tready=0` from the start of frame 0, `FIFO_DEPTH=16` → `overflow` pulses on the 17th pixel. No further writes until the next vsync fall. Frame 1 arrives intact with `tuser`.
- Short line of 5 pixels with `H_ACTIVE=8` → `line_err` pulse, no `tlast` emitted, the rest of the frame dropped, next frame correct.
- Long line of 10 pixels → 8 beats with `tlast` on the 8th, `line_err` on the 9th pixel, the rest of the frame dropped.
- Random `tready` (50%) across 10 frames → zero loss, and data/`tuser`/`tlast` held stable while stalled.
- `rst` asserted mid-line → `tvalid=0` immediately. The first beat after release is the next frame's `tuser` pixel. With STAT_EN defined, `frame_cnt` counts correctly and `drop_cnt`=1 after the overflow test.
